// File: rtl/rv32i_types.sv
// Shared types for the instruction-memory responder: FSM state encoding,
// default memory placement and address/byte-mask helpers.
package rv32i_types;

    typedef enum logic [1:0] {
        IMEM_IDLE = 2'd0,
        IMEM_WAIT = 2'd1,
        IMEM_RESP = 2'd2
    } imem_state_e;

    localparam logic [31:0] IMEM_BASE_ADDR   = 32'h1ECE_B000;
    localparam int          IMEM_DEPTH_WORDS = 1024;

    // 33-bit compare so a window ending at the top of the address space cannot wrap
    function automatic logic addr_in_range(input logic [31:0] a,
                                           input logic [31:0] base,
                                           input int unsigned depth);
        logic [32:0] lo;
        logic [32:0] hi;
        lo = {1'b0, base};
        hi = lo + (33'(depth) << 2);
        return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

endpackage

// File: rtl/imem_array.sv
// Backing word store: one synchronous write port and one synchronous read port.
// A read and write to the same word on one edge returns the old contents.
module imem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: accepts one fetch at a time, inserts a
// programmable number of wait states, then pulses a single-cycle response.
module imem_responder
    import rv32i_types::*;
#(
    parameter logic [31:0] BASE_ADDR   = IMEM_BASE_ADDR,
    parameter int          DEPTH_WORDS = IMEM_DEPTH_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    input  logic [3:0]  wait_cycles,
    output logic        imem_resp,
    output logic [31:0] imem_rdata,
    output logic        imem_err,
    output logic        busy,
    input  logic        load_we,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int AW = $clog2(DEPTH_WORDS);

    imem_state_e state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic [3:0]  rmask_q;
    logic        err_q;

    logic          accept;
    logic          enter_resp;
    logic [31:0]   rd_addr;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] ld_idx;
    logic          ld_ok;
    logic [31:0]   arr_rdata;

    assign accept     = (imem_rmask != 4'h0) && (state_q != IMEM_WAIT);
    assign enter_resp = accept ? (wait_cycles == 4'd0)
                               : ((state_q == IMEM_WAIT) && (cnt_q == 4'd1));

    // The word is read on the edge entering RESP, from the live address when
    // that edge is also the accept edge, otherwise from the latched one.
    assign rd_addr = accept ? imem_addr : addr_q;
    assign rd_idx  = AW'((rd_addr - BASE_ADDR) >> 2);
    assign ld_idx  = AW'((load_addr - BASE_ADDR) >> 2);
    assign ld_ok   = load_we && !rst && addr_in_range(load_addr, BASE_ADDR, DEPTH_WORDS);

    imem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
        .clk   (clk),
        .we    (ld_ok),
        .waddr (ld_idx),
        .wdata (load_data),
        .re    (enter_resp && !rst),
        .raddr (rd_idx),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IMEM_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            rmask_q <= 4'h0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IMEM_IDLE, IMEM_RESP: begin
                    if (accept) begin
                        addr_q  <= imem_addr;
                        rmask_q <= imem_rmask;
                        cnt_q   <= wait_cycles;
                        err_q   <= (imem_addr[1:0] != 2'b00) ||
                                   !addr_in_range(imem_addr, BASE_ADDR, DEPTH_WORDS);
                        state_q <= (wait_cycles == 4'd0) ? IMEM_RESP : IMEM_WAIT;
                    end else begin
                        state_q <= IMEM_IDLE;
                    end
                end
                IMEM_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= IMEM_RESP;
                end
                default: state_q <= IMEM_IDLE;
            endcase
        end
    end

    assign imem_resp  = (state_q == IMEM_RESP);
    assign imem_err   = imem_resp && err_q;
    assign imem_rdata = (imem_resp && !err_q) ? (arr_rdata & byte_mask(rmask_q)) : 32'h0;
    assign busy       = (state_q == IMEM_WAIT);

endmodule

// File: tb/tb_imem_responder.sv
// Directed-vector bench for imem_responder with hand-computed expectations.
module tb_imem_responder;

    localparam logic [31:0] BASE = 32'h1ECE_B000;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [3:0]  wait_cycles;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic        busy;
    logic        load_we;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    int n_pass = 0;
    int n_tot  = 0;

    imem_responder dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rmask  (imem_rmask),
        .wait_cycles (wait_cycles),
        .imem_resp   (imem_resp),
        .imem_rdata  (imem_rdata),
        .imem_err    (imem_err),
        .busy        (busy),
        .load_we     (load_we),
        .load_addr   (load_addr),
        .load_data   (load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance one edge; inputs and checks both sit 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        load_we = 1'b1; load_addr = a; load_data = d;
        tick();
        load_we = 1'b0;
    endtask

    task automatic req(input logic [31:0] a, input logic [3:0] m, input logic [3:0] w);
        imem_addr = a; imem_rmask = m; wait_cycles = w;
    endtask

    task automatic idle_req();
        imem_rmask = 4'h0;
    endtask

    // Single-cycle fetch with wait 0: accept, check response, drop request.
    task automatic fetch0(input string tag, input logic [31:0] a, input logic [3:0] m,
                          input logic [31:0] exp_data, input logic exp_err);
        req(a, m, 4'd0);
        tick();
        idle_req();
        chk({tag, "_resp"}, 32'(imem_resp), 32'd1);
        chk({tag, "_data"}, imem_rdata, exp_data);
        chk({tag, "_err"},  32'(imem_err), 32'(exp_err));
        tick();
    endtask

    int pulses;

    initial begin
        rst = 1'b1; load_we = 1'b0; load_addr = 32'h0; load_data = 32'h0;
        imem_addr = 32'h0; imem_rmask = 4'h0; wait_cycles = 4'd0;
        tick(); tick();
        chk("rst_resp",  32'(imem_resp), 32'd0);
        chk("rst_rdata", imem_rdata,     32'd0);
        chk("rst_err",   32'(imem_err),  32'd0);
        chk("rst_busy",  32'(busy),      32'd0);

        // Load while in reset must be ignored.
        load(BASE + 32'd8, 32'h0BAD_0BAD);
        rst = 1'b0;

        load(BASE,              32'h0000_0013);
        load(BASE + 32'd4,      32'hAAAA_5555);
        load(BASE + 32'd8,      32'h1234_5678);
        load(BASE + 32'd4092,   32'hCAFE_F00D);
        load(BASE - 32'd4,      32'hDEAD_BEEF);   // out of range, dropped
        load(BASE + 32'd4096,   32'hDEAD_BEEF);   // out of range, dropped

        fetch0("basic", BASE, 4'hF, 32'h0000_0013, 1'b0);
        chk("idle_resp", 32'(imem_resp), 32'd0);
        chk("idle_rdata", imem_rdata, 32'd0);
        fetch0("mask5", BASE + 32'd4, 4'h5, 32'h00AA_0055, 1'b0);
        fetch0("lastword", BASE + 32'd4092, 4'hF, 32'hCAFE_F00D, 1'b0);
        fetch0("rstload", BASE + 32'd8, 4'hF, 32'h1234_5678, 1'b0);
        fetch0("word0_nowrap", BASE, 4'hF, 32'h0000_0013, 1'b0);

        // Wait states: 3 busy cycles, response on the 4th; requests while busy ignored.
        req(BASE + 32'd8, 4'hF, 4'd3);
        tick();
        chk("w3_busy1", 32'(busy), 32'd1);
        chk("w3_resp1", 32'(imem_resp), 32'd0);
        req(BASE, 4'hF, 4'd0);
        tick();
        chk("w3_busy2", 32'(busy), 32'd1);
        tick();
        chk("w3_busy3", 32'(busy), 32'd1);
        chk("w3_resp3", 32'(imem_resp), 32'd0);
        idle_req();
        tick();
        chk("w3_resp4", 32'(imem_resp), 32'd1);
        chk("w3_busy4", 32'(busy), 32'd0);
        chk("w3_data",  imem_rdata, 32'h1234_5678);
        tick();
        chk("w3_after_resp", 32'(imem_resp), 32'd0);
        tick();
        chk("w3_no_extra", 32'(imem_resp), 32'd0);

        // Back-to-back at wait 0: one response per cycle, in order.
        req(BASE, 4'hF, 4'd0);
        tick();
        chk("b2b0_resp", 32'(imem_resp), 32'd1);
        chk("b2b0_data", imem_rdata, 32'h0000_0013);
        req(BASE + 32'd4, 4'hF, 4'd0);
        tick();
        chk("b2b1_resp", 32'(imem_resp), 32'd1);
        chk("b2b1_data", imem_rdata, 32'hAAAA_5555);
        req(BASE + 32'd8, 4'hF, 4'd0);
        tick();
        chk("b2b2_resp", 32'(imem_resp), 32'd1);
        chk("b2b2_data", imem_rdata, 32'h1234_5678);
        idle_req();
        tick();
        chk("b2b_end", 32'(imem_resp), 32'd0);

        // Error cases.
        fetch0("misalign",  BASE + 32'd2,    4'hF, 32'h0, 1'b1);
        fetch0("past_end",  BASE + 32'd4096, 4'hF, 32'h0, 1'b1);
        fetch0("below",     BASE - 32'd4,    4'hF, 32'h0, 1'b1);
        fetch0("top",       32'hFFFF_FFFC,   4'hF, 32'h0, 1'b1);

        // Error with wait states keeps the same latency.
        req(BASE + 32'd1, 4'hF, 4'd1);
        tick();
        idle_req();
        chk("err_w1_busy", 32'(busy), 32'd1);
        tick();
        chk("err_w1_resp", 32'(imem_resp), 32'd1);
        chk("err_w1_err",  32'(imem_err),  32'd1);
        tick();

        // Reset in WAIT discards the request.
        req(BASE, 4'hF, 4'd5);
        tick();
        idle_req();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw_busy", 32'(busy), 32'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (imem_resp) pulses++;
            tick();
        end
        chk("rstw_no_resp", 32'(pulses), 32'd0);
        fetch0("after_rst", BASE + 32'd4, 4'hF, 32'hAAAA_5555, 1'b0);

        // Load on the edge entering RESP: old data now, new data on refetch.
        req(BASE + 32'd4, 4'hF, 4'd0);
        load_we = 1'b1; load_addr = BASE + 32'd4; load_data = 32'h1111_2222;
        tick();
        load_we = 1'b0;
        idle_req();
        chk("raw_old", imem_rdata, 32'hAAAA_5555);
        tick();
        fetch0("raw_new", BASE + 32'd4, 4'hF, 32'h1111_2222, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
